// File: rtl/quad_count_decoder.sv
// Quadrature (A/B Gray-code) decoder producing a wrapping up/down position count,
// with input synchronizers, a reset-time phase baseline and a sticky illegal-transition flag.
module quad_count_decoder #(
    parameter int CNT_WIDTH   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 clear,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 count_up_down,
    output logic                 step,
    output logic                 error
);

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int INIT_W = $clog2(SYNC_STAGES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES - 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [0:0]             state;
    logic [INIT_W-1:0]      init_cnt;
    logic [1:0]             ph;
    logic [1:0]             ph_next;
    logic [1:0]             ph_prev;
    logic [1:0]             pos;
    logic [1:0]             pos_prev;
    logic [1:0]             delta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], enc_a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], enc_b};
        end
    end

    // ph_next is the value the last stage takes at this edge, so the baseline
    // loaded at the end of INIT is already a real input sample.
    assign ph      = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
    assign ph_next = {a_sync[SYNC_STAGES-2], b_sync[SYNC_STAGES-2]};

    // Gray-to-binary position: the modulo-4 difference gives 1 = up, 3 = down, 2 = illegal.
    assign pos      = {ph[1], ph[1] ^ ph[0]};
    assign pos_prev = {ph_prev[1], ph_prev[1] ^ ph_prev[0]};
    assign delta    = pos - pos_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= INIT;
            init_cnt      <= '0;
            ph_prev       <= '0;
            counter       <= '0;
            count_up_down <= 1'b1;
            step          <= 1'b0;
            error         <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                INIT: begin
                    if (clear) begin
                        counter <= '0;
                        error   <= 1'b0;
                    end
                    if (init_cnt == INIT_LAST) begin
                        ph_prev <= ph_next;
                        state   <= RUN;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end
                RUN: begin
                    ph_prev <= ph;
                    if (clear) begin
                        counter <= '0;
                        error   <= 1'b0;
                    end else begin
                        case (delta)
                            2'd1: begin
                                counter       <= counter + CNT_WIDTH'(1);
                                count_up_down <= 1'b1;
                                step          <= 1'b1;
                            end
                            2'd3: begin
                                counter       <= counter - CNT_WIDTH'(1);
                                count_up_down <= 1'b0;
                                step          <= 1'b1;
                            end
                            2'd2: error <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_count_decoder.sv
// Directed, table-driven bench for quad_count_decoder at default parameters
// (CNT_WIDTH = 3, SYNC_STAGES = 2).
module tb_quad_count_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic       clear;
    logic [2:0] counter;
    logic       count_up_down;
    logic       step;
    logic       error;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] cur_cnt;

    typedef struct {
        logic       a;
        logic       b;
        logic [2:0] cnt;
        logic       cud;
        logic       stp;
        logic       err;
    } vec_t;

    vec_t vecs[23];

    quad_count_decoder #(.CNT_WIDTH(3), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .enc_a        (enc_a),
        .enc_b        (enc_b),
        .clear        (clear),
        .counter      (counter),
        .count_up_down(count_up_down),
        .step         (step),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Phase change is sampled at the next edge k; outputs must move exactly at k+2.
    task automatic apply_stimulus(input int idx);
        enc_a = vecs[idx].a;
        enc_b = vecs[idx].b;
        cycle();
        cycle();
        check_output($sformatf("v%0d_early_cnt", idx), int'(counter), int'(cur_cnt));
        check_output($sformatf("v%0d_early_step", idx), int'(step), 0);
        cycle();
        check_output($sformatf("v%0d_cnt", idx), int'(counter), int'(vecs[idx].cnt));
        check_output($sformatf("v%0d_dir", idx), int'(count_up_down), int'(vecs[idx].cud));
        check_output($sformatf("v%0d_step", idx), int'(step), int'(vecs[idx].stp));
        check_output($sformatf("v%0d_err", idx), int'(error), int'(vecs[idx].err));
        cycle();
        check_output($sformatf("v%0d_step_end", idx), int'(step), 0);
        cur_cnt = vecs[idx].cnt;
    endtask

    task automatic check_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            check_output($sformatf("%s_cnt%0d", name, i), int'(counter), 0);
            check_output($sformatf("%s_step%0d", name, i), int'(step), 0);
            check_output($sformatf("%s_err%0d", name, i), int'(error), 0);
        end
    endtask

    initial begin
        // count up from baseline 00 through a wrap
        vecs[0]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 3'd6, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd7, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
        // after clear at phase 10: count down through underflow, then illegal 00->11
        vecs[11] = '{1'b1, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1};
        // after clear collision at phase 11: count up to 5
        vecs[16] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0};
        // after reset re-baselined at phase 11
        vecs[22] = '{1'b1, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0};

        reset = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        clear = 1'b0;
        #1;
        check_output("reset_cnt", int'(counter), 0);
        check_output("reset_dir", int'(count_up_down), 1);
        check_output("reset_step", int'(step), 0);
        check_output("reset_err", int'(error), 0);

        // phases held at 11 through reset must not look like a 00->11 event
        repeat (3) cycle();
        reset = 1'b0;
        check_quiet("init11", 8);

        // re-baseline at 00 for the counting sequences
        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        check_quiet("init00", 6);
        cur_cnt = 3'd0;

        for (int i = 0; i <= 10; i++) apply_stimulus(i);

        // clear with no phase activity: counter zeroed, direction kept
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check_output("clear_cnt", int'(counter), 0);
        check_output("clear_dir", int'(count_up_down), 1);
        check_output("clear_step", int'(step), 0);
        cur_cnt = 3'd0;

        for (int i = 11; i <= 15; i++) apply_stimulus(i);

        // clear lands on the same edge as the 01->11 forward step
        enc_a = 1'b1;
        enc_b = 1'b1;
        cycle();
        cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        check_output("coll_cnt", int'(counter), 0);
        check_output("coll_err", int'(error), 0);
        check_output("coll_step", int'(step), 0);
        check_output("coll_dir", int'(count_up_down), 0);
        cycle();
        check_output("coll_after_cnt", int'(counter), 0);
        check_output("coll_after_step", int'(step), 0);
        cur_cnt = 3'd0;

        for (int i = 16; i <= 20; i++) apply_stimulus(i);

        // last step to 6, then reset asserted between edges while step is high
        enc_a = vecs[21].a;
        enc_b = vecs[21].b;
        repeat (3) cycle();
        check_output("pre_rst_cnt", int'(counter), 6);
        check_output("pre_rst_step", int'(step), 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("mid_rst_cnt", int'(counter), 0);
        check_output("mid_rst_step", int'(step), 0);
        check_output("mid_rst_dir", int'(count_up_down), 1);
        enc_a = 1'b1;
        enc_b = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        check_quiet("rebase", 6);
        cur_cnt = 3'd0;

        apply_stimulus(22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
